// File: rtl/mem_stage_dmem_sized.sv
// MIPS MEM stage: byte-lane data memory with sized, extended loads, a sequential
// clear FSM, alignment/range checking and the MEM/WB pipeline register.
module mem_stage_dmem_sized #(
    parameter int  DEPTH_WORDS = 256,
    localparam int WIDX_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_stall,
    input  logic              i_clear_req,
    input  logic [31:0]       i_mem_alu_result_or_addr,
    input  logic [31:0]       i_mem_write_data,
    input  logic [4:0]        i_mem_rd,
    input  logic              i_m_mem_read,
    input  logic              i_m_mem_write,
    input  logic [1:0]        i_m_mem_size,
    input  logic              i_m_mem_unsigned,
    input  logic              i_m_mem_to_reg,
    input  logic              i_m_reg_write,
    input  logic [WIDX_W-1:0] i_dbg_addr,
    output logic [4:0]        o_m_rd,
    output logic              o_m_reg_write,
    output logic              o_m_busy,
    output logic              o_m_addr_err,
    output logic [31:0]       o_m_wb_read_data,
    output logic [31:0]       o_m_wb_alu_result,
    output logic [4:0]        o_m_wb_rd,
    output logic              o_m_wb_mem_to_reg,
    output logic              o_m_wb_reg_write,
    output logic [31:0]       o_dbg_data,
    output logic              o_dbg_state
);

    typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

    state_t            state;
    logic [WIDX_W-1:0] idx;
    logic [31:0]       mem [DEPTH_WORDS];

    logic [31:0]       addr;
    logic [WIDX_W-1:0] widx;
    logic              access;
    logic              out_of_range;
    logic              err;
    logic              store_en;
    logic [31:0]       word_rd;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [31:0]       load_v;

    assign addr         = i_mem_alu_result_or_addr;
    assign widx         = addr[WIDX_W+1:2];
    assign access       = i_m_mem_read | i_m_mem_write;
    assign out_of_range = |addr[31:WIDX_W+2];

    always_comb begin
        err = 1'b0;
        if (access) begin
            case (i_m_mem_size)
                2'b00:   err = out_of_range;
                2'b01:   err = out_of_range | addr[0];
                2'b10:   err = out_of_range | (addr[1:0] != 2'b00);
                default: err = 1'b1;
            endcase
        end
    end

    assign o_m_addr_err  = err;
    assign o_m_rd        = i_mem_rd;
    assign o_m_reg_write = i_m_reg_write;
    // Busy is the stage's not-ready: while high, upstream holds its instruction
    // and this stage injects bubbles; i_stall freezes MEM/WB and beats the bubble.
    assign o_m_busy      = (state == CLEAR);
    assign o_dbg_state   = state;
    assign o_dbg_data    = mem[i_dbg_addr];
    assign store_en      = i_m_mem_write & ~err & (state == READY);

    assign word_rd = mem[widx];

    always_comb begin
        byte_v = word_rd[7:0];
        case (addr[1:0])
            2'b01:   byte_v = word_rd[15:8];
            2'b10:   byte_v = word_rd[23:16];
            2'b11:   byte_v = word_rd[31:24];
            default: byte_v = word_rd[7:0];
        endcase
        half_v = addr[1] ? word_rd[31:16] : word_rd[15:0];
        load_v = word_rd;
        case (i_m_mem_size)
            2'b00:   load_v = i_m_mem_unsigned ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
            2'b01:   load_v = i_m_mem_unsigned ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
            default: load_v = word_rd;
        endcase
    end

    // Memory has no reset; only the clear FSM zeroes it, one word per edge.
    always_ff @(posedge i_clk) begin
        if (state == CLEAR) begin
            mem[idx] <= '0;
        end else if (store_en) begin
            case (i_m_mem_size)
                2'b00:   mem[widx][{addr[1:0], 3'b000} +: 8]  <= i_mem_write_data[7:0];
                2'b01:   mem[widx][{addr[1], 4'b0000} +: 16] <= i_mem_write_data[15:0];
                default: mem[widx]                           <= i_mem_write_data;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= CLEAR;
            idx   <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    idx <= idx + 1'b1;
                    if (idx == WIDX_W'(DEPTH_WORDS - 1)) state <= READY;
                end
                default: begin
                    if (i_clear_req) begin
                        state <= CLEAR;
                        idx   <= '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_m_wb_read_data  <= '0;
            o_m_wb_alu_result <= '0;
            o_m_wb_rd         <= '0;
            o_m_wb_mem_to_reg <= 1'b0;
            o_m_wb_reg_write  <= 1'b0;
        end else if (!i_stall) begin
            if (o_m_busy) begin
                o_m_wb_read_data  <= '0;
                o_m_wb_alu_result <= '0;
                o_m_wb_rd         <= '0;
                o_m_wb_mem_to_reg <= 1'b0;
                o_m_wb_reg_write  <= 1'b0;
            end else begin
                o_m_wb_read_data  <= (i_m_mem_read && !err) ? load_v : 32'd0;
                o_m_wb_alu_result <= addr;
                o_m_wb_rd         <= i_mem_rd;
                o_m_wb_mem_to_reg <= i_m_mem_to_reg;
                o_m_wb_reg_write  <= i_m_reg_write & ~err;
            end
        end
    end

endmodule
